// File: rtl/instruction_loader_pkg.sv
// Shared instruction constants for the program loader: the HALT marker word
// and the loader FSM state encodings.
package instruction_loader_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Big-endian byte-to-word assembler: bytes shift in from the right, so the
// first byte of a word ends up in the most significant position.
module word_assembler #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [NB_BYTE-1:0] rx_byte,
    output logic [NB_DATA-1:0] assembled,
    output logic               word_complete
);

    localparam int BYTES  = NB_DATA / NB_BYTE;
    localparam int NB_CNT = $clog2(BYTES);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(BYTES - 1);

    logic [NB_CNT-1:0] byte_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            assembled  <= '0;
            byte_count <= '0;
        end else if (clear) begin
            assembled  <= '0;
            byte_count <= '0;
        end else if (shift_en) begin
            assembled  <= {assembled[NB_DATA-NB_BYTE-1:0], rx_byte};
            byte_count <= byte_count + NB_CNT'(1);
        end
    end

    // The counter wraps back to zero on the last byte, so the next word starts cleanly.
    assign word_complete = shift_en && (byte_count == CNT_LAST);

endmodule

// File: rtl/instruction_loader.sv
// Loads a program received byte-by-byte from a UART into instruction memory,
// stopping on a HALT word or when the memory is full.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0] o_imem_data,
    output logic               o_loading,
    output logic               o_load_done,
    output logic               o_overflow,
    output logic [NB_ADDR:0]   o_instr_count
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;
    localparam logic [NB_DATA-1:0] HALT      = NB_DATA'(HALT_WORD);

    state_t state;
    logic   accept;
    logic   clear;
    logic   word_complete;

    // Bytes are taken in WRITE too, so a byte arriving right after a word is not lost.
    assign accept = i_rx_done && ((state == RECEIVE) || (state == WRITE));
    assign clear  = i_load_start && ((state == IDLE) || (state == DONE));

    word_assembler #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_assembler (
        .clk           (i_clk),
        .rst           (i_reset),
        .clear         (clear),
        .shift_en      (accept),
        .rx_byte       (i_rx_data),
        .assembled     (o_imem_data),
        .word_complete (word_complete)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            o_imem_we     <= 1'b0;
            o_imem_addr   <= '0;
            o_loading     <= 1'b0;
            o_load_done   <= 1'b0;
            o_overflow    <= 1'b0;
            o_instr_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_load_start) begin
                        state         <= RECEIVE;
                        o_imem_addr   <= '0;
                        o_instr_count <= '0;
                        o_load_done   <= 1'b0;
                        o_overflow    <= 1'b0;
                        o_loading     <= 1'b1;
                    end
                end
                RECEIVE: begin
                    if (word_complete) begin
                        state     <= WRITE;
                        o_imem_we <= 1'b1;
                    end
                end
                WRITE: begin
                    o_imem_we     <= 1'b0;
                    o_instr_count <= o_instr_count + (NB_ADDR+1)'(1);
                    // HALT wins over a full memory: a HALT in the last slot is a clean finish.
                    if (o_imem_data == HALT) begin
                        state       <= DONE;
                        o_loading   <= 1'b0;
                        o_load_done <= 1'b1;
                    end else if (o_imem_addr == LAST_ADDR) begin
                        state       <= DONE;
                        o_loading   <= 1'b0;
                        o_load_done <= 1'b1;
                        o_overflow  <= 1'b1;
                    end else begin
                        state       <= RECEIVE;
                        o_imem_addr <= o_imem_addr + NB_ADDR'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_imem_we <= 1'b0;
                    o_loading <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: table-driven word loads with a
// write scoreboard, plus hand-written sequences for the multi-cycle corner cases.
module tb_instruction_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_word;
    } vec_t;

    logic        i_clk;
    logic        i_reset;
    logic        i_load_start;
    logic        small_load_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;

    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        loading;
    logic        load_done;
    logic        overflow;
    logic [8:0]  instr_count;

    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_data;
    logic        s_loading;
    logic        s_load_done;
    logic        s_overflow;
    logic [2:0]  s_instr_count;

    wr_t  exp_q[$];
    wr_t  exp_small_q[$];
    int   total = 0;
    int   bad   = 0;
    logic [7:0] next_addr;
    logic [7:0] small_addr;
    vec_t vecs[2];
    vec_t ovf_vecs[4];

    instruction_loader #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(8)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load_start  (i_load_start),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .o_imem_we     (imem_we),
        .o_imem_addr   (imem_addr),
        .o_imem_data   (imem_data),
        .o_loading     (loading),
        .o_load_done   (load_done),
        .o_overflow    (overflow),
        .o_instr_count (instr_count)
    );

    instruction_loader #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(2)) dut_small (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load_start  (small_load_start),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .o_imem_we     (s_imem_we),
        .o_imem_addr   (s_imem_addr),
        .o_imem_data   (s_imem_data),
        .o_loading     (s_loading),
        .o_load_done   (s_load_done),
        .o_overflow    (s_overflow),
        .o_instr_count (s_instr_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Writes are sampled on the falling edge and matched against the scoreboard.
    task automatic tick();
        wr_t exp;
        @(negedge i_clk);
        if (imem_we) begin
            if (exp_q.size() == 0) check_output("unexpected_write", {24'd0, imem_addr, imem_data}, 64'd0);
            else begin
                exp = exp_q.pop_front();
                check_output("write", {24'd0, imem_addr, imem_data}, {24'd0, exp});
            end
        end
        if (s_imem_we) begin
            if (exp_small_q.size() == 0) check_output("unexpected_small_write", {30'd0, s_imem_addr, s_imem_data}, 64'd0);
            else begin
                exp = exp_small_q.pop_front();
                check_output("small_write", {30'd0, s_imem_addr, s_imem_data}, {24'd0, exp});
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_start();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v, input bit to_small);
        send_byte(v.b0);
        send_byte(v.b1);
        send_byte(v.b2);
        if (to_small) begin
            exp_small_q.push_back('{addr: small_addr, data: v.exp_word});
            small_addr = small_addr + 8'd1;
        end else begin
            exp_q.push_back('{addr: next_addr, data: v.exp_word});
            next_addr = next_addr + 8'd1;
        end
        send_byte(v.b3);
    endtask

    initial begin
        vecs[0]     = '{8'h20, 8'h01, 8'h00, 8'h05, 32'h2001_0005};
        vecs[1]     = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
        ovf_vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h1122_3344};
        ovf_vecs[1] = '{8'h55, 8'h66, 8'h77, 8'h88, 32'h5566_7788};
        ovf_vecs[2] = '{8'h99, 8'hAA, 8'hBB, 8'hCC, 32'h99AA_BBCC};
        ovf_vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 32'hFFFF_FFFE};

        i_reset = 1'b1;
        i_load_start = 1'b0;
        small_load_start = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        next_addr = 8'd0;
        small_addr = 8'd0;
        #2;
        check_output("rst_we", {63'd0, imem_we}, 64'd0);
        check_output("rst_addr", {56'd0, imem_addr}, 64'd0);
        check_output("rst_loading", {63'd0, loading}, 64'd0);
        check_output("rst_done", {63'd0, load_done}, 64'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        tick();

        // Basic load: one instruction followed by HALT.
        pulse_start();
        check_output("loading_on", {63'd0, loading}, 64'd1);
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], 1'b0);
            check_output("we_latency", {63'd0, imem_we}, 64'd1);
        end
        tick();
        check_output("halt_count", {55'd0, instr_count}, 64'd2);
        check_output("halt_done", {63'd0, load_done}, 64'd1);
        check_output("halt_overflow", {63'd0, overflow}, 64'd0);
        check_output("halt_loading", {63'd0, loading}, 64'd0);

        // Restart after DONE, byte during WRITE, and ignored start mid-RECEIVE.
        pulse_start();
        next_addr = 8'd0;
        check_output("restart_done", {63'd0, load_done}, 64'd0);
        check_output("restart_count", {55'd0, instr_count}, 64'd0);
        check_output("restart_loading", {63'd0, loading}, 64'd1);
        apply_stimulus('{8'h8C, 8'h22, 8'h00, 8'h04, 32'h8C22_0004}, 1'b0);
        send_byte(8'h3C);
        check_output("write_byte_count", {55'd0, instr_count}, 64'd1);
        check_output("write_byte_data", {32'd0, imem_data}, {32'd0, 32'h2200_043C});
        send_byte(8'h00);
        pulse_start();
        check_output("ignored_start_addr", {56'd0, imem_addr}, 64'd1);
        check_output("ignored_start_data", {32'd0, imem_data}, {32'd0, 32'h0004_3C00});
        check_output("ignored_start_loading", {63'd0, loading}, 64'd1);
        send_byte(8'h00);
        exp_q.push_back('{addr: 8'd1, data: 32'h3C00_0001});
        next_addr = 8'd2;
        send_byte(8'h01);
        apply_stimulus(vecs[1], 1'b0);
        tick();
        check_output("second_count", {55'd0, instr_count}, 64'd3);
        check_output("second_done", {63'd0, load_done}, 64'd1);

        // Reset in the middle of a word, then bytes while IDLE.
        pulse_start();
        next_addr = 8'd0;
        send_byte(8'h12);
        send_byte(8'h34);
        i_reset = 1'b1;
        #2;
        check_output("midrst_data", {32'd0, imem_data}, 64'd0);
        check_output("midrst_count", {55'd0, instr_count}, 64'd0);
        check_output("midrst_loading", {63'd0, loading}, 64'd0);
        tick();
        i_reset = 1'b0;
        send_byte(8'hAB);
        send_byte(8'hCD);
        check_output("idle_rx_data", {32'd0, imem_data}, 64'd0);
        check_output("idle_rx_addr", {56'd0, imem_addr}, 64'd0);
        check_output("idle_rx_loading", {63'd0, loading}, 64'd0);
        pulse_start();
        apply_stimulus('{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000}, 1'b0);
        apply_stimulus(vecs[1], 1'b0);
        tick();
        check_output("after_rst_count", {55'd0, instr_count}, 64'd2);
        check_output("after_rst_done", {63'd0, load_done}, 64'd1);

        // Overflow on the 2-bit address instance; the main instance sits in DONE.
        small_load_start = 1'b1;
        tick();
        small_load_start = 1'b0;
        small_addr = 8'd0;
        foreach (ovf_vecs[i]) apply_stimulus(ovf_vecs[i], 1'b1);
        tick();
        check_output("ovf_flag", {63'd0, s_overflow}, 64'd1);
        check_output("ovf_done", {63'd0, s_load_done}, 64'd1);
        check_output("ovf_count", {61'd0, s_instr_count}, 64'd4);
        check_output("ovf_loading", {63'd0, s_loading}, 64'd0);
        tick();

        check_output("pending_writes", 64'(exp_q.size()), 64'd0);
        check_output("pending_small_writes", 64'(exp_small_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, instruction word width.
REQ-002 The block SHALL have parameter NB_BYTE, default 8, received byte width.
REQ-003 The block SHALL have parameter NB_ADDR, default 8, instruction memory word-address width.
REQ-004 The block SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-005 The block SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port i_load_start  input  1  one-cycle request to begin a program load.
REQ-007 The block SHALL have port i_rx_data  input  NB_BYTE  byte from UART receiver.
REQ-008 The block SHALL have port i_rx_done  input  1  one-cycle pulse; i_rx_data valid this cycle.
REQ-009 The block SHALL have port o_imem_we  output  1  instruction memory write strobe.
REQ-010 The block SHALL have port o_imem_addr  output  NB_ADDR  instruction memory word address.
REQ-011 The block SHALL have port o_imem_data  output  NB_DATA  instruction word to write.
REQ-012 The block SHALL have port o_loading  output  1  high while a load is in progress (pipeline held).
REQ-013 The block SHALL have port o_load_done  output  1  level, high after load completes until next i_load_start.
REQ-014 The block SHALL have port o_overflow  output  1  level, memory filled without HALT word.
REQ-015 The block SHALL have port o_instr_count  output  NB_ADDR+1  words written in the current/last load.

Function
REQ-016 The block SHALL implement FSM states IDLE, RECEIVE, WRITE, DONE.
REQ-017 IDLE/DONE: i_load_start SHALL clear byte counter, address, o_instr_count, o_load_done, o_overflow, and enter RECEIVE next cycle.
REQ-018 RECEIVE: each i_rx_done SHALL shift i_rx_data into the assembly register, first byte landing in bits [31:24] (big-endian).
REQ-019 The 4th accepted byte SHALL move the FSM to WRITE on the next edge with the assembled word in o_imem_data.
REQ-020 WRITE SHALL last exactly one cycle with o_imem_we=1, o_imem_addr=current address; o_imem_we SHALL be 0 in all other states.
REQ-021 After WRITE, o_instr_count SHALL increment by one.
REQ-022 If the written word equals HALT_WORD (32'hFFFFFFFF), the FSM SHALL enter DONE; the HALT word is written to memory.
REQ-023 If the written address equals 2^NB_ADDR-1 and the word is not HALT_WORD, the FSM SHALL enter DONE and set o_overflow=1.
REQ-024 Otherwise WRITE SHALL increment the address and return to RECEIVE.
REQ-025 An i_rx_done during the WRITE cycle SHALL be accepted as byte 0 of the next word (no byte loss).
REQ-026 i_load_start in RECEIVE or WRITE SHALL be ignored.
REQ-027 i_rx_done in IDLE or DONE SHALL be ignored and SHALL NOT alter assembly state.
REQ-028 o_loading SHALL be 1 exactly in RECEIVE and WRITE; o_load_done SHALL be 1 exactly in DONE.
REQ-029 Latency: o_imem_we SHALL assert the cycle after the 4th i_rx_done pulse.

Reset
REQ-030 i_reset=1 SHALL asynchronously force state IDLE and all outputs, address, byte counter and assembly register to zero.
REQ-031 Reset mid-load SHALL abandon the partial word without any further memory write; the next load restarts at address 0.

Structure
REQ-032 HALT_WORD and the FSM state encodings SHALL live in the shared instruction constants header, not local literals.
REQ-033 Byte assembly (shift register + 2-bit byte counter) SHALL be a sub-module named word_assembler; FSM, address and flags stay in instruction_loader.

Verification
REQ-034 Reset then load bytes 20 01 00 05, FF FF FF FF -> writes 0x20010005 @0, 0xFFFFFFFF @1; o_instr_count=2, o_load_done=1, o_overflow=0.
REQ-035 Byte on i_rx_done in WRITE cycle: bytes 8C,22,00,04 then next byte 3C arriving during WRITE -> next word begins 0x3C; no byte lost.
REQ-036 NB_ADDR=2, load 4 non-HALT words -> writes @0..@3, o_overflow=1, o_load_done=1, o_instr_count=4.
REQ-037 Assert i_reset after 2 bytes of word 1 -> no o_imem_we, outputs zero; new load of 00000000,FFFFFFFF writes @0,@1.
REQ-038 i_load_start pulsed mid-RECEIVE and i_rx_done pulsed in IDLE -> no state, address or data change.
REQ-039 Second i_load_start after DONE -> o_load_done drops, count resets to 0, next word written at address 0.
